ip_top_blur: RTL and testbench

- Streaming 3x3 image smoothing filter for 8-bit greyscale frames, IMG_WIDTH x IMG_HEIGHT, delivered in raster order.
- Sits between an AXI-stream-like pixel source and sink.
- Emits exactly one filtered pixel per input pixel, in raster order, using zero padding outside the image.
- Flushes the final rows internally, and raises intr when a frame's output is complete.

---
 rtl/ip_top_blur.sv | 164 ++++++++++++++++
 tb/tb_ip_top_blur.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ip_top_blur.sv
// Streaming 3x3 smoothing filter, zero padded, one output per input pixel in raster order.
// Define GAUSS_KERNEL_EN for the 1-2-1 Gaussian kernel (sum>>4); the default is a box filter (sum/9).
module ip_top_blur #(
  parameter int IMG_WIDTH  = 512,
  parameter int IMG_HEIGHT = 512
) (
  input  logic       axi_clk,
  input  logic       axi_rst,
  input  logic       i_data_valid,
  input  logic [7:0] i_data,
  output logic       o_data_ready,
  output logic       o_data_valid,
  output logic [7:0] o_data,
  input  logic       i_data_ready,
  output logic       intr
);
  localparam int AW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam int CW = $clog2(IMG_WIDTH + 2);
  localparam logic [AW-1:0] LAST_C     = AW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] LAST_R     = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] FILL_N     = CW'(IMG_WIDTH + 1);
  localparam logic [CW-1:0] FLUSH_LAST = CW'(IMG_WIDTH);

  logic [7:0]    r_lb0 [IMG_WIDTH];
  logic [7:0]    r_lb1 [IMG_WIDTH];
  logic [7:0]    r_win [3][3];
  logic [AW-1:0] r_in_c, r_cc;
  logic [RW-1:0] r_in_r, r_cr;
  logic [CW-1:0] r_fill, r_fcnt;
  logic          r_flush;
  logic          r_vld_p1, r_intr_p1;
  logic [7:0]    r_data_p1;

  logic          w_adv, w_acc, w_beat, w_out, w_last_ctr;
  logic [7:0]    w_pix;
  logic [7:0]    w_newcol [3];
  logic [7:0]    w_tap [3][3];
  logic [11:0]   w_sum;

  function automatic logic [7:0] f_scale(input logic [11:0] s);
`ifdef GAUSS_KERNEL_EN
    return s[11:4];
`else
    return 8'(s / 12'd9);
`endif
  endfunction

  assign w_adv        = i_data_ready | ~r_vld_p1;
  assign o_data_ready = axi_rst & ~r_flush & w_adv;
  assign w_acc        = i_data_valid & o_data_ready;
  assign w_beat       = w_acc | (r_flush & w_adv);
  assign w_pix        = r_flush ? 8'd0 : i_data;
  assign w_out        = (r_fill == FILL_N);
  assign w_last_ctr   = (r_cr == LAST_R) && (r_cc == LAST_C);

  // Stage 0: new window column (two rows up, one row up, newest) and masked taps
  always_comb begin
    w_newcol[0] = r_lb0[r_in_c];
    w_newcol[1] = r_lb1[r_in_c];
    w_newcol[2] = w_pix;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        logic [7:0] src;
        logic       ok;
        src = (c == 0) ? r_win[r][1] : (c == 1) ? r_win[r][2] : w_newcol[r];
        ok  = 1'b1;
        if (r == 0 && r_cr == '0)   ok = 1'b0;
        if (r == 2 && r_cr == LAST_R) ok = 1'b0;
        if (c == 0 && r_cc == '0)   ok = 1'b0;
        if (c == 2 && r_cc == LAST_C) ok = 1'b0;
        w_tap[r][c] = ok ? src : 8'd0;
      end
    end
  end

  always_comb begin
    w_sum = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
`ifdef GAUSS_KERNEL_EN
        w_sum = w_sum + (12'(w_tap[r][c]) << ((r == 1 ? 1 : 0) + (c == 1 ? 1 : 0)));
`else
        w_sum = w_sum + 12'(w_tap[r][c]);
`endif
      end
    end
  end

  // Line buffers and window hold data only; stale contents are masked by coordinates
  always_ff @(posedge axi_clk) begin
    if (w_beat) begin
      r_lb1[r_in_c] <= w_pix;
      r_lb0[r_in_c] <= w_newcol[1];
      for (int r = 0; r < 3; r++) begin
        r_win[r][0] <= r_win[r][1];
        r_win[r][1] <= r_win[r][2];
        r_win[r][2] <= w_newcol[r];
      end
    end
  end

  // Stage 1: position counters, flush control and registered output
  always_ff @(posedge axi_clk or negedge axi_rst) begin
    if (!axi_rst) begin
      r_in_c    <= '0;
      r_in_r    <= '0;
      r_cc      <= '0;
      r_cr      <= '0;
      r_fill    <= '0;
      r_fcnt    <= '0;
      r_flush   <= 1'b0;
      r_vld_p1  <= 1'b0;
      r_intr_p1 <= 1'b0;
      r_data_p1 <= 8'd0;
    end else begin
      if (w_beat) begin
        r_in_c <= (r_in_c == LAST_C) ? '0 : r_in_c + 1'b1;
        if (!r_flush) begin
          if (r_in_c == LAST_C) begin
            if (r_in_r == LAST_R) begin
              r_in_r  <= '0;
              r_flush <= 1'b1;
              r_fcnt  <= '0;
            end else begin
              r_in_r <= r_in_r + 1'b1;
            end
          end
        end else begin
          r_fcnt <= r_fcnt + 1'b1;
        end
        if (r_fill != FILL_N) r_fill <= r_fill + 1'b1;
        if (w_out) begin
          if (r_cc == LAST_C) begin
            r_cc <= '0;
            r_cr <= (r_cr == LAST_R) ? '0 : r_cr + 1'b1;
          end else begin
            r_cc <= r_cc + 1'b1;
          end
        end
        // Last flush beat emits the final pixel; rearm for the next frame
        if (r_flush && r_fcnt == FLUSH_LAST) begin
          r_flush <= 1'b0;
          r_in_c  <= '0;
          r_fill  <= '0;
          r_cc    <= '0;
          r_cr    <= '0;
        end
      end
      if (w_beat && w_out) begin
        r_vld_p1  <= 1'b1;
        r_data_p1 <= f_scale(w_sum);
        r_intr_p1 <= w_last_ctr;
      end else begin
        r_intr_p1 <= 1'b0;
        if (w_adv) r_vld_p1 <= 1'b0;
      end
    end
  end

  assign o_data_valid = r_vld_p1;
  assign o_data       = r_data_p1;
  assign intr         = r_intr_p1;
endmodule

// File: tb/tb_ip_top_blur.sv
// Directed bench for ip_top_blur on a small 8x6 frame (box kernel, or Gaussian with GAUSS_KERNEL_EN).
module tb_ip_top_blur;
  localparam int W = 8;
  localparam int H = 6;
  localparam int NPIX = W * H;
`ifdef GAUSS_KERNEL_EN
  localparam int EXP_CORNER = 50, EXP_EDGE = 67, EXP_R00 = 1, EXP_IMP = 63;
`else
  localparam int EXP_CORNER = 40, EXP_EDGE = 60, EXP_R00 = 2, EXP_IMP = 28;
`endif

  logic       axi_clk = 1'b0;
  logic       axi_rst = 1'b0;
  logic       i_data_valid = 1'b0;
  logic [7:0] i_data = 8'd0;
  logic       o_data_ready, o_data_valid, intr;
  logic [7:0] o_data;
  logic       i_data_ready = 1'b1;

  int img [NPIX];
  int out_q [$];
  int acc_q [$];
  int intr_q [$];
  int acc_cnt = 0;
  int stall_err = 0;
  bit prev_stall = 0;
  logic [7:0] prev_data = 8'd0;
  int n_vec = 0;
  int n_err = 0;

  ip_top_blur #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .axi_clk(axi_clk), .axi_rst(axi_rst),
    .i_data_valid(i_data_valid), .i_data(i_data), .o_data_ready(o_data_ready),
    .o_data_valid(o_data_valid), .o_data(o_data), .i_data_ready(i_data_ready),
    .intr(intr)
  );

  always #5 axi_clk = ~axi_clk;

  always @(negedge axi_clk) begin
    if (axi_rst && intr) intr_q.push_back(out_q.size());
    if (axi_rst && o_data_valid && i_data_ready) begin
      out_q.push_back(int'(o_data));
      acc_q.push_back(acc_cnt);
    end
    if (o_data_ready && i_data_valid) acc_cnt++;
    if (axi_rst) begin
      if (prev_stall && (!o_data_valid || o_data !== prev_data)) stall_err++;
      if (o_data_valid && !i_data_ready && o_data_ready) stall_err++;
    end
    prev_stall = axi_rst && o_data_valid && !i_data_ready;
    prev_data  = o_data;
  end

  function automatic int exp_pix(int r, int c);
    int s;
    s = 0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        if (r + dr >= 0 && r + dr < H && c + dc >= 0 && c + dc < W)
`ifdef GAUSS_KERNEL_EN
          s += img[(r + dr) * W + c + dc] * (dr == 0 ? 2 : 1) * (dc == 0 ? 2 : 1);
    return s / 16;
`else
          s += img[(r + dr) * W + c + dc];
    return s / 9;
`endif
  endfunction

  task automatic drive_pixels(input int npix, input bit rnd, input int stop_at);
    int idx, cyc;
    idx = 0;
    cyc = 0;
    @(posedge axi_clk); #1;
    i_data_valid = 1'b1;
    i_data = 8'(img[0]);
    while (idx < npix && idx < stop_at && cyc < 3000) begin
      @(negedge axi_clk);
      if (o_data_ready) idx++;
      @(posedge axi_clk); #1;
      i_data_valid = (idx < npix && idx < stop_at);
      i_data = 8'(img[idx % NPIX]);
      if (rnd) i_data_ready = 1'($urandom_range(0, 1));
      cyc++;
    end
    i_data_valid = 1'b0;
    if (cyc >= 3000) begin
      n_vec++; n_err++;
      $display("FAIL drive_timeout: accepted %0d, required %0d", idx, npix);
    end
  endtask

  task automatic wait_outputs(input int base, input int count, input bit rnd);
    int cyc;
    cyc = 0;
    while (out_q.size() - base < count && cyc < 3000) begin
      @(posedge axi_clk); #1;
      if (rnd) i_data_ready = 1'($urandom_range(0, 1));
      @(negedge axi_clk);
      cyc++;
    end
    @(posedge axi_clk); #1;
    i_data_ready = 1'b1;
    repeat (4) @(posedge axi_clk);
    #1;
    if (cyc >= 3000) begin
      n_vec++; n_err++;
      $display("FAIL output_timeout: got %0d outputs, required %0d", out_q.size() - base, count);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge axi_clk);
    @(negedge axi_clk);
    n_vec++; if (o_data_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", o_data_valid); end
    n_vec++; if (o_data !== 8'd0) begin n_err++; $display("FAIL rst_data: got %0d want 0", o_data); end
    n_vec++; if (intr !== 1'b0) begin n_err++; $display("FAIL rst_intr: got %b want 0", intr); end
    n_vec++; if (o_data_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %b want 0", o_data_ready); end
    @(posedge axi_clk); #1;
    axi_rst = 1'b1;
    @(posedge axi_clk); #1;
  endtask

  task automatic test_const90();
    int base, ibase, abase;
    for (int i = 0; i < NPIX; i++) img[i] = 90;
    base = out_q.size(); ibase = intr_q.size(); abase = acc_cnt;
    drive_pixels(NPIX, 1'b0, NPIX);
    wait_outputs(base, NPIX, 1'b0);
    n_vec++; if (out_q.size() - base != NPIX) begin n_err++; $display("FAIL const_count: got %0d want %0d", out_q.size() - base, NPIX); end
    if (out_q.size() - base >= NPIX) begin
      n_vec++; if (out_q[base] != EXP_CORNER) begin n_err++; $display("FAIL const_corner: got %0d want %0d", out_q[base], EXP_CORNER); end
      n_vec++; if (out_q[base + 1] != EXP_EDGE) begin n_err++; $display("FAIL const_edge: got %0d want %0d", out_q[base + 1], EXP_EDGE); end
      n_vec++; if (out_q[base + W + 1] != 90) begin n_err++; $display("FAIL const_interior: got %0d want 90", out_q[base + W + 1]); end
      n_vec++; if (out_q[base + NPIX - 1] != EXP_CORNER) begin n_err++; $display("FAIL const_last_corner: got %0d want %0d", out_q[base + NPIX - 1], EXP_CORNER); end
      n_vec++; if (acc_q[base] - abase != W + 2) begin n_err++; $display("FAIL first_latency: accepts %0d want %0d", acc_q[base] - abase, W + 2); end
      for (int i = 0; i < NPIX; i++) begin
        n_vec++; if (out_q[base + i] != exp_pix(i / W, i % W)) begin n_err++; $display("FAIL const_pix%0d: got %0d want %0d", i, out_q[base + i], exp_pix(i / W, i % W)); end
      end
    end
    n_vec++; if (intr_q.size() - ibase != 1) begin n_err++; $display("FAIL const_intr_count: got %0d want 1", intr_q.size() - ibase); end
    else begin
      n_vec++; if (intr_q[ibase] != base + NPIX - 1) begin n_err++; $display("FAIL const_intr_pos: got %0d want %0d", intr_q[ibase] - base, NPIX - 1); end
    end
  endtask

  task automatic test_ramp_flush();
    int base, lowc, cyc;
    for (int i = 0; i < NPIX; i++) img[i] = i;
    base = out_q.size();
    drive_pixels(NPIX, 1'b0, NPIX);
    lowc = 0; cyc = 0;
    @(negedge axi_clk);
    while (!o_data_ready && cyc < 50) begin
      lowc++; cyc++;
      @(negedge axi_clk);
    end
    n_vec++; if (lowc != W + 1) begin n_err++; $display("FAIL flush_ready_low: got %0d cycles want %0d", lowc, W + 1); end
    wait_outputs(base, NPIX, 1'b0);
    n_vec++; if (out_q.size() - base != NPIX) begin n_err++; $display("FAIL ramp_count: got %0d want %0d", out_q.size() - base, NPIX); end
    if (out_q.size() - base >= NPIX) begin
      n_vec++; if (out_q[base] != EXP_R00) begin n_err++; $display("FAIL ramp_00: got %0d want %0d", out_q[base], EXP_R00); end
      n_vec++; if (out_q[base + W + 1] != 9) begin n_err++; $display("FAIL ramp_11: got %0d want 9", out_q[base + W + 1]); end
      for (int i = 0; i < NPIX; i++) begin
        n_vec++; if (out_q[base + i] != exp_pix(i / W, i % W)) begin n_err++; $display("FAIL ramp_pix%0d: got %0d want %0d", i, out_q[base + i], exp_pix(i / W, i % W)); end
      end
    end
  endtask

  task automatic test_impulse();
    int base, nz;
    for (int i = 0; i < NPIX; i++) img[i] = 0;
    img[2 * W + 3] = 255;
    base = out_q.size();
    drive_pixels(NPIX, 1'b0, NPIX);
    wait_outputs(base, NPIX, 1'b0);
    if (out_q.size() - base >= NPIX) begin
      nz = 0;
      for (int i = 0; i < NPIX; i++) if (out_q[base + i] != 0) nz++;
      n_vec++; if (nz != 9) begin n_err++; $display("FAIL impulse_nonzero: got %0d want 9", nz); end
      n_vec++; if (out_q[base + 2 * W + 3] != EXP_IMP) begin n_err++; $display("FAIL impulse_centre: got %0d want %0d", out_q[base + 2 * W + 3], EXP_IMP); end
      for (int i = 0; i < NPIX; i++) begin
        n_vec++; if (out_q[base + i] != exp_pix(i / W, i % W)) begin n_err++; $display("FAIL impulse_pix%0d: got %0d want %0d", i, out_q[base + i], exp_pix(i / W, i % W)); end
      end
    end else begin
      n_vec++; n_err++; $display("FAIL impulse_count: got %0d want %0d", out_q.size() - base, NPIX);
    end
  endtask

  task automatic test_backpressure();
    int base, ibase;
    for (int i = 0; i < NPIX; i++) img[i] = (i * 37 + 11) % 256;
    base = out_q.size(); ibase = intr_q.size();
    stall_err = 0;
    drive_pixels(NPIX, 1'b1, NPIX);
    wait_outputs(base, NPIX, 1'b1);
    n_vec++; if (stall_err != 0) begin n_err++; $display("FAIL stall_hold: got %0d violations want 0", stall_err); end
    n_vec++; if (out_q.size() - base != NPIX) begin n_err++; $display("FAIL bp_count: got %0d want %0d", out_q.size() - base, NPIX); end
    n_vec++; if (intr_q.size() - ibase != 1) begin n_err++; $display("FAIL bp_intr: got %0d want 1", intr_q.size() - ibase); end
    if (out_q.size() - base >= NPIX)
      for (int i = 0; i < NPIX; i++) begin
        n_vec++; if (out_q[base + i] != exp_pix(i / W, i % W)) begin n_err++; $display("FAIL bp_pix%0d: got %0d want %0d", i, out_q[base + i], exp_pix(i / W, i % W)); end
      end
  endtask

  task automatic test_midframe_reset();
    int base, ibase;
    for (int i = 0; i < NPIX; i++) img[i] = (i * 5) % 256;
    drive_pixels(NPIX, 1'b0, 5 * W + 2);
    axi_rst = 1'b0;
    #1;
    n_vec++; if (o_data_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid: got %b want 0", o_data_valid); end
    n_vec++; if (o_data !== 8'd0) begin n_err++; $display("FAIL mid_rst_data: got %0d want 0", o_data); end
    n_vec++; if (o_data_ready !== 1'b0) begin n_err++; $display("FAIL mid_rst_ready: got %b want 0", o_data_ready); end
    repeat (2) @(posedge axi_clk);
    #1;
    axi_rst = 1'b1;
    base = out_q.size(); ibase = intr_q.size();
    drive_pixels(NPIX, 1'b0, NPIX);
    wait_outputs(base, NPIX, 1'b0);
    n_vec++; if (intr_q.size() - ibase != 1) begin n_err++; $display("FAIL mid_intr: got %0d want 1", intr_q.size() - ibase); end
    n_vec++; if (out_q.size() - base != NPIX) begin n_err++; $display("FAIL mid_count: got %0d want %0d", out_q.size() - base, NPIX); end
    if (out_q.size() - base >= NPIX)
      for (int i = 0; i < NPIX; i++) begin
        n_vec++; if (out_q[base + i] != exp_pix(i / W, i % W)) begin n_err++; $display("FAIL mid_pix%0d: got %0d want %0d", i, out_q[base + i], exp_pix(i / W, i % W)); end
      end
  endtask

  task automatic test_back_to_back();
    int base, ibase;
    for (int i = 0; i < NPIX; i++) img[i] = (i * 13) % 256;
    base = out_q.size(); ibase = intr_q.size();
    drive_pixels(2 * NPIX, 1'b0, 2 * NPIX);
    wait_outputs(base, 2 * NPIX, 1'b0);
    n_vec++; if (out_q.size() - base != 2 * NPIX) begin n_err++; $display("FAIL b2b_count: got %0d want %0d", out_q.size() - base, 2 * NPIX); end
    n_vec++; if (intr_q.size() - ibase != 2) begin n_err++; $display("FAIL b2b_intr: got %0d want 2", intr_q.size() - ibase); end
    else begin
      n_vec++; if (intr_q[ibase + 1] != base + 2 * NPIX - 1) begin n_err++; $display("FAIL b2b_intr_pos: got %0d want %0d", intr_q[ibase + 1] - base, 2 * NPIX - 1); end
    end
    if (out_q.size() - base >= 2 * NPIX)
      for (int i = 0; i < 2 * NPIX; i++) begin
        n_vec++; if (out_q[base + i] != exp_pix((i % NPIX) / W, i % W)) begin n_err++; $display("FAIL b2b_pix%0d: got %0d want %0d", i, out_q[base + i], exp_pix((i % NPIX) / W, i % W)); end
      end
  endtask

  initial begin
    test_reset();
    test_const90();
    test_ramp_flush();
    test_impulse();
    test_backpressure();
    test_midframe_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, vectors %0d", n_vec);
    $fatal(1, "watchdog");
  end
endmodule
